tetris_input_ctrl: RTL and testbench
====================================

# tetris_input_ctrl

Parametrised player-input conditioner for the Tetris LED game. It replaces the fixed two-button right/left move latch. Per button it provides:
- synchronisation and debounce;
- a single move pulse per press;
- delayed auto-repeat while the button is held;
- priority arbitration among mutually exclusive moves.

It sits between the raw board buttons and the game-state logic, which consumes one-cycle `move` pulses.

## Interface
- `NUM_BTN`, 4: number of button channels (index 0 right, 1 left, 2 rotate, 3 drop).
- `DEB_CYCLES`, 16: consecutive cycles a synchronised input must differ from the stable level before the stable level flips; ≥1.
- `DAS_CYCLES`, 200: cycles from press pulse to first auto-repeat pulse; ≥1.
- `ARR_CYCLES`, 50: cycles between subsequent auto-repeat pulses; ≥1.
- `REPEAT_EN`, 4'b0011: per-channel auto-repeat enable (default right/left only).
- `EXCL_MASK`, 4'b0011: channels that are mutually exclusive; lowest index wins.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  game-active; low during pause/line-clear.
- `btn`  in  NUM_BTN  raw asynchronous button levels, active-high.
- `move`  out  NUM_BTN  one-cycle move pulses, registered.
- `held`  out  NUM_BTN  debounced button levels, registered.

## Operation
- Reset (async assert, sync release) values:
  - `move`=0, `held`=0;
  - synchroniser flops, debounce counters and repeat counters = 0;
  - all channel FSMs = IDLE.
- Sync: 2-flop synchroniser per channel; only the second flop feeds downstream.
- Debounce: counter increments each cycle the synchronised input ≠ stable level. It clears on any cycle they are equal. When it is at DEB_CYCLES-1 and still differing, the stable level flips and the counter clears. `held` = stable level.
- Press event: stable level rising edge.
- Channel FSM:
  - IDLE → HELD on press event; emit press pulse; clear repeat counter.
  - HELD: counter increments each cycle. At DAS_CYCLES-1, emit pulse, clear counter, → REPEAT. This transition occurs only if `REPEAT_EN[i]`; otherwise the FSM stays in HELD with the counter saturated.
  - REPEAT: at ARR_CYCLES-1, emit pulse and clear counter.
  - HELD/REPEAT → IDLE when the stable level falls; no pulse is emitted that cycle.
- `en` low: FSMs forced to IDLE and all pulses masked; debounce and `held` keep running. A button held across a pause emits nothing until it is released and pressed again.
- Arbitration is applied to candidate pulses before the output register:
  - Among candidates with `EXCL_MASK` set, only the lowest index passes.
  - Losing pulses are dropped, not deferred; the losers' FSM timing is unaffected.
  - Non-masked channels always pass.
- Counter widths: `$clog2` of the relevant parameter, plus 1. No wrap is possible, because counters clear at terminal count.

## Timing
- Press latency: with the raw rise sampled at edge 1, `held` rises after edge DEB_CYCLES+2. `move` is high for exactly one cycle after edge DEB_CYCLES+3.
- First repeat: DAS_CYCLES cycles after the press pulse.
- Later repeats: every ARR_CYCLES cycles.
- Release latency: `held` falls DEB_CYCLES+2 edges after a clean raw fall. No pulse is emitted at or after that edge.
- Glitch rejection: a sync-level excursion shorter than DEB_CYCLES cycles leaves `held` and the FSM unchanged.
- Release coinciding with a repeat terminal count: the release wins and no pulse is emitted.
- Async `rst` mid-hold: outputs drop immediately. After release of reset, a still-held button produces a fresh press after normal debounce latency.
- `move` never has more than one `EXCL_MASK` bit set in the same cycle.

## Structure
- Shared package `tetris_pkg`:
  - button index constants `BTN_RIGHT`=0, `BTN_LEFT`=1, `BTN_ROT`=2, `BTN_DROP`=3;
  - channel FSM state enum (IDLE, HELD, REPEAT).
- Sub-module `tetris_btn_chan`, one per channel via generate. It contains the synchroniser, debounce counter, repeat FSM and counter, and produces `held` and a candidate pulse.
- The top level holds the `en` masking, the priority arbiter and the output registers.

## Test plan
Parameters for all scenarios: DEB_CYCLES=4, DAS_CYCLES=10, ARR_CYCLES=3.
- Reset: assert `rst` with `btn`=4'b1111 → `move`=0 and `held`=0 immediately. After release, the first `move[0]` pulse appears after edge 7.
- Glitch: `btn[2]` high for 3 cycles, then low → `held[2]` and `move` stay 0 throughout.
- Hold `btn[0]` for 30 cycles:
  - press pulse at edge 7;
  - repeats at edges 17, 20, 23, 26, 29, 32, 35;
  - no pulse after `held[0]` falls.
- Hold `btn[3]` for 30 cycles (REPEAT_EN[3]=0) → exactly one `move[3]` pulse.
- Press `btn[0]` and `btn[1]` on the same cycle and hold both:
  - every right pulse passes and every left pulse is dropped;
  - `move[1:0]` is never 2'b11.
- Drop `en` while `btn[1]` is held → no pulses while `en`=0. Raise `en` with the button still held → still no pulses. Release and re-press → press pulse after edge 7 from the re-press.

Source files
------------

// File: rtl/tetris_pkg.sv
// tetris_pkg: shared button indices and channel FSM state for the Tetris input conditioner
package tetris_pkg;
    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_ROT   = 2;
    localparam int BTN_DROP  = 3;
    typedef enum logic [1:0] {IDLE, HELD, REPEAT} chan_state_e;
endpackage

// File: rtl/tetris_btn_chan.sv
// tetris_btn_chan: one button channel - synchroniser, debounce, press/auto-repeat FSM
module tetris_btn_chan
    import tetris_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int DAS_CYCLES = 200,
    parameter int ARR_CYCLES = 50,
    parameter bit REPEAT_ON  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic btn,
    output logic held,
    output logic pulse
);
    localparam int DW   = $clog2(DEB_CYCLES) + 1;
    localparam int RMAX = DAS_CYCLES > ARR_CYCLES ? DAS_CYCLES : ARR_CYCLES;
    localparam int RW   = $clog2(RMAX) + 1;
    logic          sync_a, sync_b, stable, stable_q, flip, live, press, das_tc, arr_tc;
    logic [DW-1:0] dcnt;
    logic [RW-1:0] rcnt, rcnt_nxt;
    chan_state_e   state, state_nxt;
    assign flip   = (sync_b != stable) && (dcnt == DW'(DEB_CYCLES - 1));
    assign live   = stable && !flip;
    assign press  = stable && !stable_q;
    assign das_tc = rcnt == RW'(DAS_CYCLES - 1);
    assign arr_tc = rcnt == RW'(ARR_CYCLES - 1);
    assign held   = stable;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a   <= 1'b0;
            sync_b   <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            dcnt     <= '0;
        end else begin
            sync_a   <= btn;
            sync_b   <= sync_a;
            stable_q <= stable;
            if (sync_b == stable) dcnt <= '0;
            else if (flip) begin
                stable <= ~stable;
                dcnt   <= '0;
            end else dcnt <= dcnt + DW'(1);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rcnt  <= '0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
        end
    end
    // HELD without repeat parks at the DAS terminal count instead of wrapping
    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        if (!en) begin
            state_nxt = IDLE;
            rcnt_nxt  = '0;
        end else begin
            case (state)
                IDLE: if (press) begin
                    state_nxt = HELD;
                    rcnt_nxt  = '0;
                end
                HELD: if (!stable) state_nxt = IDLE;
                    else if (!das_tc) rcnt_nxt = rcnt + RW'(1);
                    else if (REPEAT_ON) begin
                        state_nxt = REPEAT;
                        rcnt_nxt  = '0;
                    end
                REPEAT: if (!stable) state_nxt = IDLE;
                    else rcnt_nxt = arr_tc ? '0 : rcnt + RW'(1);
                default: state_nxt = IDLE;
            endcase
        end
    end
    // a pulse due in the cycle the stable level drops is suppressed: release wins
    always_comb begin
        pulse = (state == IDLE && press)
             || (state == HELD && REPEAT_ON && live && das_tc)
             || (state == REPEAT && live && arr_tc);
    end
endmodule

// File: rtl/tetris_input_ctrl.sv
// tetris_input_ctrl: per-button debounce/auto-repeat channels, enable masking and
// lowest-index arbitration among mutually exclusive moves
module tetris_input_ctrl
    import tetris_pkg::*;
#(
    parameter int                 NUM_BTN    = 4,
    parameter int                 DEB_CYCLES = 16,
    parameter int                 DAS_CYCLES = 200,
    parameter int                 ARR_CYCLES = 50,
    parameter logic [NUM_BTN-1:0] REPEAT_EN  = 4'b0011,
    parameter logic [NUM_BTN-1:0] EXCL_MASK  = 4'b0011
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_BTN-1:0] btn,
    output logic [NUM_BTN-1:0] move,
    output logic [NUM_BTN-1:0] held
);
    logic [NUM_BTN-1:0] pulse, cand, win;
    logic               found;
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        tetris_btn_chan #(
            .DEB_CYCLES(DEB_CYCLES),
            .DAS_CYCLES(DAS_CYCLES),
            .ARR_CYCLES(ARR_CYCLES),
            .REPEAT_ON (REPEAT_EN[g])
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .btn  (btn[g]),
            .held (held[g]),
            .pulse(pulse[g])
        );
    end
    // losers are simply dropped; their channel timing carries on untouched
    always_comb begin
        cand  = pulse & {NUM_BTN{en}};
        win   = cand;
        found = 1'b0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (EXCL_MASK[i]) begin
                if (found) win[i] = 1'b0;
                found = found | cand[i];
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) move <= '0;
        else move <= win;
    end
endmodule

// File: tb/tb_tetris_input_ctrl.sv
// tb_tetris_input_ctrl: table-driven scoreboard bench for tetris_input_ctrl
// with hand-written reset and pause sequences
module tb_tetris_input_ctrl;
    import tetris_pkg::*;
    localparam int DEB = 4;
    localparam int DAS = 10;
    localparam int ARR = 3;
    localparam logic [3:0] REP  = 4'b0011;
    localparam logic [3:0] EXCL = 4'b0011;
    typedef struct {logic [3:0] b; int hold; string tag;} vec_t;
    typedef struct {logic [3:0] mv; logic [3:0] hd;} exp_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [3:0] btn = 4'b0000;
    logic [3:0] move, held;
    int         errors = 0;
    int         checks = 0;
    exp_t       sbq[$];
    vec_t       vecs[7];
    tetris_input_ctrl #(
        .NUM_BTN(4), .DEB_CYCLES(DEB), .DAS_CYCLES(DAS), .ARR_CYCLES(ARR),
        .REPEAT_EN(REP), .EXCL_MASK(EXCL)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .btn(btn), .move(move), .held(held)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(string name, logic [3:0] got, logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask
    // expected outputs per edge, from the documented latencies (rise sampled at edge 1)
    task automatic push_scn(logic [3:0] b, int hold, int len);
        int   press = DEB + 3;
        int   fall  = hold + DEB + 2;
        logic [3:0] cand, hd, x;
        for (int e = 1; e <= len; e++) begin
            cand = '0;
            hd   = '0;
            for (int c = 0; c < 4; c++) begin
                if (b[c] && hold >= DEB) begin
                    hd[c]   = (e >= DEB + 2) && (e < fall);
                    cand[c] = (e < fall) && ((e == press) ||
                              (REP[c] && e >= press + DAS && (e - press - DAS) % ARR == 0));
                end
            end
            x = cand & EXCL;
            sbq.push_back('{mv: (cand & ~EXCL) | (x & (~x + 4'd1)), hd: hd});
        end
    endtask
    task automatic scn(string tag, logic [3:0] b, int hold);
        int   len = hold + DEB + 8;
        exp_t ex;
        push_scn(b, hold, len);
        btn = b;
        for (int e = 1; e <= len; e++) begin
            tick();
            if (e == hold) btn = 4'b0000;
            ex = sbq.pop_front();
            check($sformatf("%s move@%0d", tag, e), move, ex.mv);
            check($sformatf("%s held@%0d", tag, e), held, ex.hd);
        end
    endtask
    initial begin
        vecs[0] = '{b: 4'b0001, hold: 30, tag: "right_hold"};
        vecs[1] = '{b: 4'b0100, hold: 3,  tag: "rot_glitch"};
        vecs[2] = '{b: 4'b1000, hold: 30, tag: "drop_norep"};
        vecs[3] = '{b: 4'b0011, hold: 30, tag: "right_left"};
        vecs[4] = '{b: 4'b0100, hold: 30, tag: "rot_norep"};
        vecs[5] = '{b: 4'b0010, hold: 12, tag: "left_edge"};
        vecs[6] = '{b: 4'b0001, hold: 8,  tag: "right_short"};
        btn = 4'b1111;
        #12;
        check("reset move", move, 4'b0000);
        check("reset held", held, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        btn = 4'b0000;
        for (int i = 0; i < 3; i++) tick();
        foreach (vecs[i]) scn(vecs[i].tag, vecs[i].b, vecs[i].hold);
        btn = 4'b1111;
        for (int e = 1; e <= 7; e++) tick();
        check("prereset move@7", move, 4'b1101);
        #2 rst = 1'b1;
        #1;
        check("midhold rst move", move, 4'b0000);
        check("midhold rst held", held, 4'b0000);
        #1 rst = 1'b0;
        scn("after_rst", 4'b1111, 12);
        btn = 4'b0010;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("pause press move@%0d", e), move, e == 7 ? 4'b0010 : 4'b0000);
        end
        en = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            check($sformatf("paused move@%0d", e), move, 4'b0000);
            check($sformatf("paused held@%0d", e), held, 4'b0010);
        end
        en = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            check($sformatf("resumed move@%0d", e), move, 4'b0000);
        end
        btn = 4'b0000;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check($sformatf("released move@%0d", e), move, 4'b0000);
        end
        scn("repress", 4'b0010, 8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
